// File: rtl/clk_div_gen.sv
// -----------------------------------------------------------------------------
// clk_div_gen -- programmable integer clock divider
//
// Produces a registered, glitch-free divided clock (clk_out) with period
// cur_div source cycles: ceil(N/2) cycles high followed by floor(N/2) cycles
// low. Odd ratios are high-biased by one cycle. Ratio changes and stop
// requests take effect only at period boundaries, so no runt pulse is ever
// emitted.
//
// Ports:
//   clk          source clock, all logic on posedge
//   rst          asynchronous active-low reset
//   en           run request (level)
//   div_val      requested divide ratio N (CNT_W bits)
//   div_load     one-cycle strobe capturing div_val as the pending ratio
//   div_ack      one-cycle pulse when a pending ratio becomes active
//   div_err      one-cycle pulse after a div_load with N < 2 (load ignored)
//   clk_out      divided clock, straight from a flop
//   clk_out_rise high in the cycle clk_out shows its 0->1 change
//   clk_out_fall high in the cycle clk_out shows its 1->0 change
//   busy         high whenever the phase machine is not IDLE
// -----------------------------------------------------------------------------
module clk_div_gen #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_out,
  output logic             clk_out_rise,
  output logic             clk_out_fall,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  // High phase = ceil(N/2). Built as floor(N/2) + lsb so that N = 2^CNT_W-1
  // does not overflow CNT_W bits (the result is at most 2^(CNT_W-1)).
  function automatic logic [CNT_W-1:0] high_len(input logic [CNT_W-1:0] n);
    high_len = (n >> 1) + {{(CNT_W-1){1'b0}}, n[0]};
  endfunction

  // Low phase = floor(N/2).
  function automatic logic [CNT_W-1:0] low_len(input logic [CNT_W-1:0] n);
    low_len = n >> 1;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] cur_div;
  logic [CNT_W-1:0] pending_div;
  logic             pending_valid;
  logic             apply_pend;
  logic             load_ok;
  logic             load_bad;

  // A ratio is legal when any bit above bit 0 is set, i.e. N >= 2.
  assign load_ok  = div_load && (div_val[CNT_W-1:1] != '0);
  assign load_bad = div_load && (div_val[CNT_W-1:1] == '0);

  assign busy = (state != IDLE);

  // Next-state logic: cnt runs 1..H in HIGH and 1..L in LOW. Periods are
  // only started (and pending ratios only applied) out of IDLE or at the
  // end of LOW; en is ignored inside a period so phases are never cut short.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    apply_pend = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en) begin
          state_nxt  = HIGH;
          cnt_nxt    = CNT_ONE;
          apply_pend = pending_valid;
        end
      end
      HIGH: begin
        if (cnt == high_len(cur_div)) begin
          state_nxt = LOW;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      LOW: begin
        if (cnt == low_len(cur_div)) begin
          if (en) begin
            state_nxt  = HIGH;
            cnt_nxt    = CNT_ONE;
            apply_pend = pending_valid;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, ratio bookkeeping and registered outputs. clk_out and its strobes
  // are registered copies of the phase state, so every output toggles from
  // a flop and the strobes line up with the cycle clk_out changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      cur_div       <= DIV_RST;
      pending_div   <= DIV_RST;
      pending_valid <= 1'b0;
      clk_out       <= 1'b0;
      clk_out_rise  <= 1'b0;
      clk_out_fall  <= 1'b0;
      div_ack       <= 1'b0;
      div_err       <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      clk_out      <= (state == HIGH);
      clk_out_rise <= (state == HIGH) && !clk_out;
      clk_out_fall <= (state != HIGH) && clk_out;
      div_ack      <= apply_pend;
      div_err      <= load_bad;
      if (apply_pend) begin
        cur_div <= pending_div;
      end
      // A load landing on a boundary edge wins over the clear, so it stays
      // pending for the following boundary.
      if (load_ok) begin
        pending_div   <= div_val;
        pending_valid <= 1'b1;
      end else if (apply_pend) begin
        pending_valid <= 1'b0;
      end
    end
  end

endmodule
